// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: round-robin burst scheduler over a 4:1 data mux with valid/ready output; define MUX4_RR_SCHEDULER_STATS_EN for per-requester grant counters
module mux4_rr_scheduler #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
`ifdef MUX4_RR_SCHEDULER_STATS_EN
  ,
  output logic [31:0]      grant_cnt
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);
  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d, ptr_q, ptr_d, win;
  logic [3:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  assign grant_cnt = grant_cnt_q;
`endif
  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign accept    = out_valid && out_ready;
  assign y         = (state_q != GRANT) ? '0 :
                     (sel_q == 2'd0) ? din_a :
                     (sel_q == 2'd1) ? din_b :
                     (sel_q == 2'd2) ? din_c : din_d;
  // first requester at or after ptr, scanning upward modulo 4
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
  end
  // next-state: grant from IDLE, release on owner drop or full burst
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
    grant_cnt_d = grant_cnt_q;
`endif
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        sel_d   = win;
        gnt_d   = 4'b0001 << win;
        cnt_d   = '0;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
        grant_cnt_d[{win, 3'b000} +: 8] = grant_cnt_q[{win, 3'b000} +: 8] + 8'd1;
`endif
      end
    end else if (!req[sel_q] || (accept && cnt_q == LAST)) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = sel_q + 2'd1;
    end else if (accept) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
      grant_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
      grant_cnt_q <= grant_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// tb_mux4_rr_scheduler: directed checks of arbitration order, burst release, handshake and async reset
module tb_mux4_rr_scheduler;
  logic       clk = 0, rst_n = 0, out_ready = 0;
  logic [3:0] req = '0;
  logic       din_a = 0, din_b = 1, din_c = 0, din_d = 1;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       y, out_valid;
  logic [3:0] dins;
  int         n_cmp = 0, n_err = 0;
`ifdef MUX4_RR_SCHEDULER_STATS_EN
  logic [31:0] grant_cnt;
`endif

  mux4_rr_scheduler #(.WIDTH(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
    .out_ready(out_ready), .sel(sel), .gnt(gnt), .y(y), .out_valid(out_valid)
`ifdef MUX4_RR_SCHEDULER_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic yy, input logic v);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".y"}, 32'(y), 32'(yy));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    dins = {din_d, din_c, din_b, din_a};
    #3;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef MUX4_RR_SCHEDULER_STATS_EN
    chk("reset.grant_cnt", grant_cnt, 32'h0);
`endif
    #10 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req = 4'b1111;
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk_out($sformatf("rot%0d.beat%0d", k, b), 4'b0001 << (k % 4), 2'(k % 4), dins[k % 4], 1'b1);
      end
      step();
      chk_out($sformatf("rot%0d.gap", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
`ifdef MUX4_RR_SCHEDULER_STATS_EN
      if (k == 3) chk("rotation.grant_cnt", grant_cnt, 32'h01010101);
`endif
    end
    req = 4'b0010;
    out_ready = 0;
    step();
    for (int i = 0; i < 7; i++) begin
      out_ready = (i % 2 == 0);
      chk_out($sformatf("toggle%0d", i), 4'b0010, 2'd1, 1'b1, 1'b1);
      step();
    end
    chk_out("toggle.release", 4'b0000, 2'd1, 1'b0, 1'b0);
    out_ready = 1;
    step();
    chk_out("toggle.regrant", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b0000;
    #1;
    chk("drop.valid", 32'(out_valid), 32'h0);
    step();
    chk_out("drop.idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b0101;
    step();
    chk_out("own2.grant", 4'b0100, 2'd2, 1'b0, 1'b1);
    step();
    step();
    req = 4'b0001;
    #1;
    chk("own2.drop.valid", 32'(out_valid), 32'h0);
    step();
    chk_out("own2.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    chk_out("own2.next_is_0", 4'b0001, 2'd0, 1'b0, 1'b1);
    din_a = 1'bx;
    req = 4'b0010;
    step();
    chk("xsel.gnt", 32'(gnt), 32'h0);
    step();
    chk_out("xsel", 4'b0010, 2'd1, 1'b1, 1'b1);
    step();
    #2 rst_n = 0;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef MUX4_RR_SCHEDULER_STATS_EN
    chk("async_rst.grant_cnt", grant_cnt, 32'h0);
`endif
    din_a = 0;
    req = 4'b1111;
    #1 rst_n = 1;
    step();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
